// File: rtl/xtal_osc_pkg.sv
// Shared definitions for the crystal oscillator monitor.
// State encoding is visible on the top-level state port.
package xtal_osc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_STANDBY = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xtal_edge_sync.sv
// Synchronizes the raw oscillator output into the reference domain
// and emits a single-cycle pulse per rising edge.
module xtal_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/xtal_osc_monitor.sv
// Crystal oscillator sequencer and frequency qualifier.
// One shared timer serves start-up, wake-up and measurement windows.
module xtal_osc_monitor
    import xtal_osc_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STARTUP_CYCLES = 4096,
    parameter int WAKE_CYCLES    = 256,
    parameter int WINDOW         = 240,
    parameter int EDGE_MIN       = 36,
    parameter int EDGE_MAX       = 44,
    parameter int LOSS_TIMEOUT   = 16,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               stdby_req,
    input  logic               xtal_dout,
    output logic               osc_ena,
    output logic               osc_stdby,
    output logic               good,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   edge_count
);

    localparam int TMR_MAX = f_max(f_max(STARTUP_CYCLES, WAKE_CYCLES), WINDOW);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int LOSS_W  = $clog2(LOSS_TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]   START_LAST = TMR_W'(STARTUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]   WAKE_LAST  = TMR_W'(WAKE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   WIN_LAST   = TMR_W'(WINDOW - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]   CNT_MIN    = CNT_W'(EDGE_MIN);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(EDGE_MAX);

    state_e             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_cnt;
    logic [LOSS_W-1:0]  r_loss;
    logic [RETRY_W-1:0] r_retry;
    logic               r_osc_ena;
    logic               r_osc_stdby;
    logic               r_good;
    logic               r_fail;
    logic [CNT_W-1:0]   r_edge_count;

    logic               w_edge;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_win_end;
    logic               w_in_range;
    logic               w_loss;
    logic [RETRY_W-1:0] w_retry_next;

    xtal_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_din (xtal_dout),
        .o_edge(w_edge)
    );

    // Edge counter saturates; the window-end edge is included in the verdict.
    assign w_cnt_next   = (&r_cnt) ? r_cnt
                        : r_cnt + {{(CNT_W-1){1'b0}}, w_edge};
    assign w_win_end    = (r_timer == WIN_LAST);
    assign w_in_range   = (w_cnt_next >= CNT_MIN) && (w_cnt_next <= CNT_MAX);
    assign w_loss       = !w_edge && (r_loss == LOSS_LAST);
    assign w_retry_next = r_retry + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_loss       <= '0;
            r_retry      <= '0;
            r_osc_ena    <= 1'b0;
            r_osc_stdby  <= 1'b0;
            r_good       <= 1'b0;
            r_fail       <= 1'b0;
            r_edge_count <= '0;
        end else if (!en) begin
            // Any partial window is dropped; edge_count keeps its last value.
            r_state     <= ST_OFF;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_loss      <= '0;
            r_retry     <= '0;
            r_osc_ena   <= 1'b0;
            r_osc_stdby <= 1'b0;
            r_good      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    r_state   <= ST_STARTUP;
                    r_osc_ena <= 1'b1;
                    r_timer   <= '0;
                end
                ST_STARTUP: begin
                    if (r_timer == START_LAST) begin
                        r_state <= ST_MEASURE;
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_win_end) begin
                        r_edge_count <= w_cnt_next;
                        r_cnt        <= '0;
                        r_timer      <= '0;
                        if (w_in_range) begin
                            r_state <= ST_RUN;
                            r_good  <= 1'b1;
                            r_loss  <= '0;
                        end else if (w_retry_next >= RETRY_LIM) begin
                            r_state   <= ST_FAULT;
                            r_osc_ena <= 1'b0;
                            r_fail    <= 1'b1;
                        end else begin
                            r_retry <= w_retry_next;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        r_cnt   <= w_cnt_next;
                    end
                end
                ST_RUN: begin
                    r_loss <= w_edge ? '0 : r_loss + 1'b1;
                    if (w_win_end) begin
                        r_edge_count <= w_cnt_next;
                        r_cnt        <= '0;
                        r_timer      <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        r_cnt   <= w_cnt_next;
                    end
                    if (w_loss || (w_win_end && !w_in_range)) begin
                        r_state <= ST_MEASURE;
                        r_good  <= 1'b0;
                        r_retry <= '0;
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_loss  <= '0;
                    end else if (stdby_req) begin
                        r_state     <= ST_STANDBY;
                        r_good      <= 1'b0;
                        r_osc_stdby <= 1'b1;
                    end
                end
                ST_STANDBY: begin
                    // osc_stdby high means still parked; low means waking.
                    if (r_osc_stdby) begin
                        if (!stdby_req) begin
                            r_osc_stdby <= 1'b0;
                            r_timer     <= '0;
                        end
                    end else if (r_timer == WAKE_LAST) begin
                        r_state <= ST_MEASURE;
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_FAULT: begin
                    r_osc_ena <= 1'b0;
                    r_fail    <= 1'b1;
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    assign osc_ena    = r_osc_ena;
    assign osc_stdby  = r_osc_stdby;
    assign good       = r_good;
    assign fail       = r_fail;
    assign state      = r_state;
    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_xtal_osc_monitor.sv
// Directed scenarios with randomized phases and delays; window counts
// are predicted from a log of driven rising transitions.
module tb_xtal_osc_monitor;
    import xtal_osc_pkg::*;

    localparam int SYNC    = 2;
    localparam int STARTUP = 20;
    localparam int WAKE    = 8;
    localparam int WIN     = 240;
    localparam int EMIN    = 36;
    localparam int EMAX    = 44;
    localparam int LOSS    = 16;
    localparam int MAXR    = 3;
    localparam int CW      = $clog2(WIN + 1);
    localparam int LAT     = SYNC + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               stdby_req;
    logic               xtal_dout;
    logic               osc_ena;
    logic               osc_stdby;
    logic               good;
    logic               fail;
    logic [STATE_W-1:0] state;
    logic [CW-1:0]      edge_count;

    xtal_osc_monitor #(
        .SYNC_STAGES(SYNC), .STARTUP_CYCLES(STARTUP), .WAKE_CYCLES(WAKE),
        .WINDOW(WIN), .EDGE_MIN(EMIN), .EDGE_MAX(EMAX),
        .LOSS_TIMEOUT(LOSS), .MAX_RETRY(MAXR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .stdby_req(stdby_req),
        .xtal_dout(xtal_dout), .osc_ena(osc_ena), .osc_stdby(osc_stdby),
        .good(good), .fail(fail), .state(state), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int tog_n = 0;
    int phase = 0;
    int total = 0;
    int bad   = 0;
    int rises[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One reference cycle: inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tog_n != 0) begin
            phase++;
            if (phase >= tog_n) begin
                phase = 0;
                xtal_dout = ~xtal_dout;
                if (xtal_dout) rises.push_back(cyc);
            end
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    // Rising edges driven after edge k are counted on edge k+LAT.
    function automatic int win_cnt(input int a, input int b);
        int n = 0;
        foreach (rises[i])
            if (rises[i] + LAT >= a && rises[i] + LAT <= b) n++;
        return n;
    endfunction

    function automatic bit in_rng(input int n);
        return (n >= EMIN) && (n <= EMAX);
    endfunction

    function automatic logic [31:0] verdict_state(input int n);
        return in_rng(n) ? 32'(ST_RUN) : 32'(ST_MEASURE);
    endfunction

    initial begin
        int e0, p, l, last, p2, r, c, r5, n, held;
        rst = 1'b1; en = 1'b0; stdby_req = 1'b0; xtal_dout = 1'b0;
        repeat (3) step();
        chk("rst_state", state, ST_OFF);
        chk("rst_ena", osc_ena, 0);
        chk("rst_stdby", osc_stdby, 0);
        chk("rst_good", good, 0);
        chk("rst_fail", fail, 0);
        chk("rst_count", edge_count, 0);
        rst = 1'b0;

        // Start-up and first qualification at N=3
        tog_n = 3;
        phase = $urandom_range(0, 2);
        repeat ($urandom_range(1, 9)) step();
        en = 1'b1;
        e0 = cyc + 1;
        step();
        chk("t1_ena", osc_ena, 1);
        chk("t1_startup", state, ST_STARTUP);
        run_to(e0 + STARTUP);
        chk("t1_measure", state, ST_MEASURE);
        run_to(e0 + STARTUP + WIN - 1);
        chk("t1_good_early", good, 0);
        step();
        n = win_cnt(e0 + STARTUP + 1, e0 + STARTUP + WIN);
        chk("t1_good", good, 32'(in_rng(n)));
        chk("t1_count", edge_count, n);
        chk("t1_state", state, verdict_state(n));
        p = cyc;

        // Loss of clock in RUN, then recovery
        run_to(p + $urandom_range(0, 60));
        tog_n = 0;
        last = rises[rises.size() - 1];
        l = ((last + LAT) > p ? (last + LAT) : p) + LOSS;
        run_to(l - 1);
        chk("t3_good_hold", good, 1);
        step();
        chk("t3_good_drop", good, 0);
        chk("t3_state", state, ST_MEASURE);
        tog_n = 3;
        phase = 0;
        run_to(l + WIN);
        n = win_cnt(l + 1, l + WIN);
        chk("t3_regood", good, 32'(in_rng(n)));
        chk("t3_count", edge_count, n);
        p2 = cyc;

        // Frequency too high for one window, then back in range
        tog_n = 2;
        phase = 0;
        run_to(p2 + WIN - 1);
        chk("t4_good_hold", good, 1);
        step();
        n = win_cnt(p2 + 1, p2 + WIN);
        chk("t4_count", edge_count, n);
        chk("t4_good", good, 32'(in_rng(n)));
        chk("t4_state", state, verdict_state(n));
        tog_n = 3;
        phase = 0;
        run_to(p2 + 2 * WIN);
        n = win_cnt(p2 + WIN + 1, p2 + 2 * WIN);
        chk("t4_recover", state, verdict_state(n));
        chk("t4_count2", edge_count, n);
        r = cyc;
        held = n;

        // Standby entry and wake
        run_to(r + $urandom_range(5, 100));
        stdby_req = 1'b1;
        step();
        chk("t5_state", state, ST_STANDBY);
        chk("t5_stdby", osc_stdby, 1);
        chk("t5_good", good, 0);
        chk("t5_ena", osc_ena, 1);
        chk("t5_held", edge_count, held);
        repeat ($urandom_range(3, 40)) step();
        stdby_req = 1'b0;
        c = cyc;
        step();
        chk("t5_stdby_clr", osc_stdby, 0);
        run_to(c + WAKE);
        chk("t5_waking", state, ST_STANDBY);
        step();
        chk("t5_measure", state, ST_MEASURE);
        run_to(c + WAKE + 1 + WIN);
        n = win_cnt(c + WAKE + 2, c + WAKE + 1 + WIN);
        chk("t5_good", good, 32'(in_rng(n)));
        chk("t5_count", edge_count, n);
        r5 = cyc;
        held = n;

        // en dropped exactly on a window-end cycle
        run_to(r5 + WIN - 1);
        en = 1'b0;
        step();
        chk("t6b_state", state, ST_OFF);
        chk("t6b_ena", osc_ena, 0);
        chk("t6b_good", good, 0);
        chk("t6b_count", edge_count, held);
        tog_n = 0;
        repeat (6) step();

        // Static crystal: retries exhausted, then FAULT
        en = 1'b1;
        e0 = cyc + 1;
        run_to(e0);
        chk("t2_ena", osc_ena, 1);
        run_to(e0 + STARTUP + WIN);
        chk("t2_retry1", state, ST_MEASURE);
        chk("t2_count", edge_count, win_cnt(e0 + STARTUP + 1, e0 + STARTUP + WIN));
        chk("t2_good", good, 0);
        run_to(e0 + STARTUP + MAXR * WIN - 1);
        chk("t2_pre_fault", state, ST_MEASURE);
        chk("t2_pre_fail", fail, 0);
        step();
        chk("t2_fault", state, ST_FAULT);
        chk("t2_fail", fail, 1);
        chk("t2_ena_off", osc_ena, 0);
        repeat (5) step();
        chk("t2_sticky", fail, 1);
        en = 1'b0;
        step();
        chk("t2_off", state, ST_OFF);
        chk("t2_fail_clr", fail, 0);

        // Reset in the middle of a measurement window
        en = 1'b1;
        tog_n = 3;
        phase = 0;
        e0 = cyc + 1;
        run_to(e0 + STARTUP + WIN);
        n = win_cnt(e0 + STARTUP + 1, e0 + STARTUP + WIN);
        chk("t6a_run", state, verdict_state(n));
        chk("t6a_count", edge_count, n);
        tog_n = 0;
        repeat (60) step();
        chk("t6a_measure", state, ST_MEASURE);
        run_to(cyc + $urandom_range(1, 100));
        rst = 1'b1;
        step();
        chk("t6a_state", state, ST_OFF);
        chk("t6a_ena", osc_ena, 0);
        chk("t6a_good", good, 0);
        chk("t6a_fail", fail, 0);
        chk("t6a_stdby", osc_stdby, 0);
        chk("t6a_count", edge_count, 0);
        rst = 1'b0;
        en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
